vga_rect_fill: RTL and testbench



---
 rtl/vga_rect_fill.sv | 176 +++++++++++++++++
 tb/tb_vga_rect_fill.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// Port-mapped rectangle fill engine for the 80x60 VGA framebuffer.
// Writes one clipped pixel per clock, row-major, from shadowed parameters.
module vga_rect_fill #(
    parameter logic [7:0] X0_ID    = 8'h94,
    parameter logic [7:0] Y0_ID    = 8'h95,
    parameter logic [7:0] W_ID     = 8'h96,
    parameter logic [7:0] H_ID     = 8'h97,
    parameter logic [7:0] COLOR_ID = 8'h98,
    parameter logic [7:0] CMD_ID   = 8'h99,
    parameter int         SCR_W    = 80,
    parameter int         SCR_H    = 60
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  PORT_ID,
    input  logic [7:0]  OUT_PORT,
    input  logic        IO_STRB,
    output logic [7:0]  STATUS,
    output logic        BUSY,
    output logic [12:0] FB_WA,
    output logic [7:0]  FB_WD,
    output logic        FB_WE
);

    localparam logic [8:0] XMAX = 9'(SCR_W);
    localparam logic [8:0] YMAX = 9'(SCR_H);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL
    } state_t;

    state_t state, state_n;

    logic [6:0] x0, sx0, cx;
    logic [5:0] y0, sy0, cy;
    logic [7:0] w, h, color, sw, sh, scol;
    logic       busy, overrun, empty;

    logic       cmd_hit;
    logic [8:0] xsum, ysum, xe, ye;
    logic       degenerate, x_more, y_more;
    logic       accept, start, empty_set, adv_x, adv_y, last;

    assign cmd_hit = IO_STRB && (PORT_ID == CMD_ID)
                     && (OUT_PORT[1] || OUT_PORT[0]);

    // Clip end coordinates; 9-bit sums cannot wrap.
    assign xsum = {2'b0, sx0} + {1'b0, sw};
    assign ysum = {3'b0, sy0} + {1'b0, sh};
    assign xe   = (xsum > XMAX) ? XMAX : xsum;
    assign ye   = (ysum > YMAX) ? YMAX : ysum;

    assign degenerate = (sw == 8'd0) || (sh == 8'd0)
                        || ({2'b0, sx0} >= XMAX)
                        || ({3'b0, sy0} >= YMAX);

    assign x_more = ({2'b0, cx} + 9'd1) < xe;
    assign y_more = ({3'b0, cy} + 9'd1) < ye;

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        start     = 1'b0;
        empty_set = 1'b0;
        adv_x     = 1'b0;
        adv_y     = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_hit) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (degenerate) begin
                    empty_set = 1'b1;
                    state_n   = IDLE;
                end else begin
                    start   = 1'b1;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (x_more) begin
                    adv_x = 1'b1;
                end else if (y_more) begin
                    adv_y = 1'b1;
                end else begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            x0      <= '0;
            y0      <= '0;
            w       <= '0;
            h       <= '0;
            color   <= '0;
            sx0     <= '0;
            sy0     <= '0;
            sw      <= '0;
            sh      <= '0;
            scol    <= '0;
            cx      <= '0;
            cy      <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            empty   <= 1'b0;
            FB_WA   <= '0;
            FB_WD   <= '0;
            FB_WE   <= 1'b0;
        end else begin
            state <= state_n;
            if (IO_STRB) begin
                case (PORT_ID)
                    X0_ID:    x0    <= OUT_PORT[6:0];
                    Y0_ID:    y0    <= OUT_PORT[5:0];
                    W_ID:     w     <= OUT_PORT;
                    H_ID:     h     <= OUT_PORT;
                    COLOR_ID: color <= OUT_PORT;
                    default:  ;
                endcase
            end
            if (accept) begin
                // Clear screen ignores the loaded geometry.
                sx0     <= OUT_PORT[1] ? 7'd0 : x0;
                sy0     <= OUT_PORT[1] ? 6'd0 : y0;
                sw      <= OUT_PORT[1] ? 8'(SCR_W) : w;
                sh      <= OUT_PORT[1] ? 8'(SCR_H) : h;
                scol    <= color;
                busy    <= 1'b1;
                overrun <= 1'b0;
                empty   <= 1'b0;
            end else if (cmd_hit && busy) begin
                overrun <= 1'b1;
            end
            if (empty_set) begin
                empty <= 1'b1;
                busy  <= 1'b0;
            end
            if (start) begin
                cx    <= sx0;
                cy    <= sy0;
                FB_WE <= 1'b1;
                FB_WA <= {sy0, sx0};
                FB_WD <= scol;
            end
            if (adv_x) begin
                cx    <= cx + 7'd1;
                FB_WA <= {cy, cx + 7'd1};
            end
            if (adv_y) begin
                cx    <= sx0;
                cy    <= cy + 6'd1;
                FB_WA <= {cy + 6'd1, sx0};
            end
            if (last) begin
                FB_WE <= 1'b0;
                busy  <= 1'b0;
            end
        end
    end

    assign BUSY   = busy;
    assign STATUS = {5'b0, empty, overrun, busy};

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: expected pixels are queued by the
// stimulus and checked by a monitor on every framebuffer write.
module tb_vga_rect_fill;

    logic        CLK;
    logic        RESET_N;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  STATUS;
    logic        BUSY;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        FB_WE;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    vga_rect_fill dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .STATUS   (STATUS),
        .BUSY     (BUSY),
        .FB_WA    (FB_WA),
        .FB_WD    (FB_WD),
        .FB_WE    (FB_WE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge CLK) begin
        if (FB_WE === 1'b1) begin
            logic [20:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected write wa=%h wd=%h",
                         FB_WA, FB_WD);
            end else begin
                e = exp_q.pop_front();
                if ({FB_WA, FB_WD} !== e) begin
                    errors++;
                    $display("FAIL pixel: got wa=%h wd=%h want wa=%h wd=%h",
                             FB_WA, FB_WD, e[20:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
    endtask

    task automatic push_rect(input int x0, input int y0, input int x1,
                             input int y1, input logic [7:0] c);
        for (int y = y0; y < y1; y++)
            for (int x = x0; x < x1; x++)
                exp_q.push_back({6'(y), 7'(x), c});
    endtask

    // Runs until FB_WE drops, then checks BUSY fell with it.
    task automatic run_fill(input string name, input int budget);
        int n = 0;
        logic busy_bad = 1'b0;
        while (FB_WE === 1'b1 && n < budget) begin
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(n >= budget), 32'd0);
        chk({name, "_busy_during"}, 32'(busy_bad), 32'd0);
        chk({name, "_busy_after"}, 32'(BUSY), 32'd0);
        chk({name, "_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N  = 1'b0;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        repeat (3) tick();
        chk("rst_status", STATUS, 8'h00);
        chk("rst_we", FB_WE, 1'b0);
        chk("rst_wa", FB_WA, 13'h0);
        chk("rst_wd", FB_WD, 8'h00);
        RESET_N = 1'b1;
        tick();

        // Basic 3x2 fill with timing checks.
        io_write(8'h94, 8'd5);
        io_write(8'h95, 8'd2);
        io_write(8'h96, 8'd3);
        io_write(8'h97, 8'd2);
        io_write(8'h98, 8'hE0);
        push_rect(5, 2, 8, 4, 8'hE0);
        io_write(8'h99, 8'h01);
        chk("t1_busy_n1", BUSY, 1'b1);
        chk("t1_we_n1", FB_WE, 1'b0);
        tick();
        chk("t1_we_n2", FB_WE, 1'b1);
        run_fill("t1", 20);
        chk("t1_status", STATUS, 8'h00);

        // Bottom-right clip.
        io_write(8'h94, 8'd78);
        io_write(8'h95, 8'd58);
        io_write(8'h96, 8'd10);
        io_write(8'h97, 8'd10);
        push_rect(78, 58, 80, 60, 8'hE0);
        io_write(8'h99, 8'h01);
        tick();
        run_fill("t2", 20);

        // Zero width, then off-screen origin.
        io_write(8'h96, 8'd0);
        io_write(8'h99, 8'h01);
        chk("t3_busy_n1", BUSY, 1'b1);
        tick();
        chk("t3_status_w0", STATUS, 8'h04);
        io_write(8'h96, 8'd5);
        io_write(8'h94, 8'd90);
        io_write(8'h99, 8'h01);
        tick();
        repeat (3) tick();
        chk("t3_status_x90", STATUS, 8'h04);

        // Clear screen with overrun and colour change mid-fill.
        io_write(8'h98, 8'h03);
        push_rect(0, 0, 80, 60, 8'h03);
        io_write(8'h99, 8'h02);
        chk("t4_status_n1", STATUS, 8'h01);
        repeat (50) tick();
        io_write(8'h99, 8'h01);
        io_write(8'h98, 8'hFF);
        chk("t4_overrun", STATUS, 8'h03);
        run_fill("t4", 6000);
        chk("t4_status_end", STATUS, 8'h02);

        // Reset mid-fill.
        push_rect(0, 0, 80, 60, 8'hFF);
        io_write(8'h99, 8'h02);
        repeat (100) tick();
        RESET_N = 1'b0;
        tick();
        chk("t5_we", FB_WE, 1'b0);
        chk("t5_status", STATUS, 8'h00);
        chk("t5_wa", FB_WA, 13'h0);
        RESET_N = 1'b1;
        exp_q.delete();
        tick();
        chk("t5_still_idle", FB_WE, 1'b0);

        // Two-pixel fill; command lands on the last-pixel cycle.
        io_write(8'h94, 8'd10);
        io_write(8'h95, 8'd20);
        io_write(8'h96, 8'd2);
        io_write(8'h97, 8'd1);
        io_write(8'h98, 8'h5A);
        push_rect(10, 20, 12, 21, 8'h5A);
        io_write(8'h99, 8'h01);
        tick();
        chk("t5_first_we", FB_WE, 1'b1);
        tick();
        chk("t5_last_busy", BUSY, 1'b1);
        io_write(8'h99, 8'h01);
        chk("t5_ovr_status", STATUS, 8'h02);
        repeat (4) tick();
        chk("t5_ovr_we", FB_WE, 1'b0);
        chk("t5_left", exp_q.size(), 32'd0);

        // No-op command leaves everything alone.
        io_write(8'h99, 8'h00);
        chk("t6_busy", BUSY, 1'b0);
        tick();
        chk("t6_status", STATUS, 8'h02);
        chk("t6_we", FB_WE, 1'b0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
